param_seq_counter: RTL and testbench
====================================

// Module: param_seq_counter
// PURPOSE
//  Parametrised successor of the 2-bit x_in-stepped state machine: WIDTH-bit
//  counter stepped by x_in, with direction, parallel load, and binary or Gray
//  output coding. Overflow is selectable between wrap and saturate.
//  The state register is built from D, JK or T flip-flops, selected at
//  elaboration. All three builds are cycle-for-cycle identical.
//  Used as the general sequencer/counter primitive in the sequential library.
// PARAMETERS
//  WIDTH      4  state/count width in bits (>=2)
//  FF_TYPE    0  register excitation style: 0=D, 1=JK, 2=T
//  CODE       0  output/load coding: 0=binary, 1=Gray (reflected binary)
//  SATURATE   0  0=wrap at terminal count, 1=hold at terminal count
//  RESET_VAL  0  binary count value loaded by reset
// PORTS
//  clock     in   1      rising-edge clock
//  reset     in   1      synchronous, active-high reset
//  x_in      in   1      step enable: 1 = advance one count this cycle
//  dir       in   1      1 = count up, 0 = count down
//  load      in   1      1 = load load_val this cycle
//  load_val  in   WIDTH  value to load, expressed in CODE coding
//  state     out  WIDTH  current count, expressed in CODE coding (registered)
//  tc        out  1      terminal count: step is requested at the end of the range (combinational)
//  wrap      out  1      one-cycle registered pulse after a wrap-around
// BEHAVIOUR
//  - Internal register cnt[WIDTH-1:0] always holds the binary count.
//  - state = cnt when CODE=0, and cnt ^ (cnt>>1) when CODE=1.
//  - Priority each rising edge: reset > load > x_in step > hold.
//  - reset=1: cnt <= RESET_VAL, wrap <= 0. Reset overrides load and x_in in
//    the same cycle, including mid-count.
//  - load=1: cnt <= load_val when CODE=0, or gray2bin(load_val) when CODE=1.
//    x_in and dir are ignored. wrap <= 0.
//  - x_in=1, load=0: cnt <= cnt+1 when dir=1, or cnt-1 when dir=0.
//  - Terminal: cnt=all-ones with dir=1, or cnt=0 with dir=0.
//  - At terminal with SATURATE=0: cnt wraps (all-ones->0 or 0->all-ones),
//    and wrap=1 for exactly the next cycle.
//  - At terminal with SATURATE=1: cnt holds and wrap stays 0.
//  - x_in=0, load=0: cnt holds and wrap <= 0.
//  - tc = x_in & ~load & ~reset & terminal(cnt,dir). Pure combinational, no
//    state. Asserts identically in wrap and saturate modes.
//  - Latency: state reflects a step, load or reset one cycle after the edge.
//    tc reflects the present inputs with zero latency.
//  - Register implementation: next-state d is computed once; excitation per bit:
//      FF_TYPE=0  q <= d
//      FF_TYPE=1  J = d & ~q, K = ~d & q, then standard JK update
//      FF_TYPE=2  T = d ^ q, then q <= q ^ T
//    Reset and load act through the same excitation path, with no bypass.
//  - Values after reset: state = RESET_VAL in CODE coding. wrap = 0. tc
//    follows its equation and is 0 while reset=1.
//  - Illegal FF_TYPE or CODE values, or WIDTH<2: elaboration error ($error
//    in a generate check).
// TESTING (WIDTH=4 unless noted)
//  1. Hold reset=1 for 2 cycles with load=1, x_in=1 -> state=0000, wrap=0,
//     tc=0. Repeat with RESET_VAL=5 -> state=0101.
//  2. CODE=0, SATURATE=0, dir=1, x_in=1 for 17 cycles from 0 -> state runs
//     0..15 then 0. tc=1 only while cnt=15. wrap=1 only in the cycle state=0
//     after 15.
//  3. CODE=1, dir=1, x_in=1 from 0 -> state sequence 0000, 0001, 0011,
//     0010, 0110, 0111. Every transition changes exactly one bit.
//  4. cnt=0, dir=0, x_in=1:
//     - SATURATE=1 -> state stays 0000, tc=1, wrap=0.
//     - SATURATE=0 -> state=1111, wrap pulses 1 cycle.
//  5. CODE=1, load=1, x_in=1, dir=1, load_val=1101 -> next state=1101 with
//     internal cnt=9. Same cycle with reset=1 -> state=RESET_VAL instead.
//  6. Instantiate FF_TYPE=0, 1 and 2 side by side. Drive 2000 cycles of
//     random x_in/dir/load/load_val with sporadic reset, for CODE in {0,1}
//     and SATURATE in {0,1} -> state, tc and wrap bit-identical on every
//     cycle.

Source files
------------

// File: rtl/param_seq_counter_if.sv
// ============================================================================
//  Module      : param_seq_counter_if
//  Description : Control/status bundle for param_seq_counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface param_seq_counter_if #(
  parameter int WIDTH = 4
);
  logic             x_in;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] state;
  logic             tc;
  logic             wrap;

  modport master (
    output x_in, dir, load, load_val,
    input  state, tc, wrap
  );

  modport slave (
    input  x_in, dir, load, load_val,
    output state, tc, wrap
  );
endinterface

`default_nettype wire

// File: rtl/param_seq_counter.sv
// ============================================================================
//  Module      : param_seq_counter
//  Description : WIDTH-bit up/down/load counter, binary or Gray coded, wrap or
//                saturate, state register built from D, JK or T flip-flops.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module param_seq_counter #(
  parameter int WIDTH     = 4,
  parameter int FF_TYPE   = 0,
  parameter int CODE      = 0,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input wire                  clock,
  input wire                  reset,
  param_seq_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_all_ones  = '1;
  localparam logic [WIDTH-1:0] c_reset_val = WIDTH'(RESET_VAL);

  if (WIDTH < 2 || FF_TYPE < 0 || FF_TYPE > 2 || CODE < 0 || CODE > 1) begin : g_param_check
    $error("param_seq_counter: illegal WIDTH/FF_TYPE/CODE combination");
  end

  logic             w_x_in;
  logic             w_dir;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_cnt;
  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_d;
  logic             w_terminal;
  logic             w_wrap_d;
  logic             r_wrap;

  assign w_x_in     = bus.x_in;
  assign w_dir      = bus.dir;
  assign w_load     = bus.load;
  assign w_load_val = bus.load_val;

  // Load value and output share the configured coding; cnt is always binary.
  if (CODE == 1) begin : g_code_gray
    always_comb begin
      w_load_bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
        w_load_bin[i] = ^(w_load_val >> i);
      end
    end
    assign bus.state = w_cnt ^ (w_cnt >> 1);
  end else begin : g_code_bin
    assign w_load_bin = w_load_val;
    assign bus.state  = w_cnt;
  end

  always_comb begin
    w_terminal = w_dir ? (w_cnt == c_all_ones) : (w_cnt == '0);
    w_d        = w_cnt;
    w_wrap_d   = 1'b0;
    if (reset) begin
      w_d = c_reset_val;
    end else if (w_load) begin
      w_d = w_load_bin;
    end else if (w_x_in) begin
      if (w_terminal && (SATURATE != 0)) begin
        w_d = w_cnt;
      end else begin
        w_d      = w_dir ? (w_cnt + 1'b1) : (w_cnt - 1'b1);
        w_wrap_d = w_terminal;
      end
    end
  end

  // Every bit, including reset and load, goes through the chosen excitation.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic r_q;
    assign w_cnt[i] = r_q;

    if (FF_TYPE == 1) begin : g_jk
      logic w_j;
      logic w_k;
      assign w_j = w_d[i] & ~r_q;
      assign w_k = ~w_d[i] & r_q;
      always_ff @(posedge clock) begin
        case ({w_j, w_k})
          2'b10:   r_q <= 1'b1;
          2'b01:   r_q <= 1'b0;
          2'b11:   r_q <= ~r_q;
          default: r_q <= r_q;
        endcase
      end
    end else if (FF_TYPE == 2) begin : g_t
      logic w_t;
      assign w_t = w_d[i] ^ r_q;
      always_ff @(posedge clock) begin
        r_q <= r_q ^ w_t;
      end
    end else begin : g_d
      always_ff @(posedge clock) begin
        r_q <= w_d[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_d;
    end
  end

  assign bus.wrap = r_wrap;
  assign bus.tc   = w_x_in & ~w_load & ~reset & w_terminal;

endmodule

`default_nettype wire

// File: tb/tb_param_seq_counter.sv
// ============================================================================
//  Module      : tb_param_seq_counter
//  Description : Twelve counter builds (FF type x coding x overflow mode) driven
//                in lockstep and compared against an arithmetic reference.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_param_seq_counter;

  localparam int c_width = 4;
  localparam int c_max   = 15;
  localparam int c_n     = 12;

  logic               clock = 1'b0;
  logic               reset;
  logic               x_in;
  logic               dir;
  logic               load;
  logic [c_width-1:0] load_val;

  logic [c_width-1:0] w_state [c_n];
  logic               w_tc    [c_n];
  logic               w_wrap  [c_n];

  int m_cnt  [c_n];
  bit m_wrap [c_n];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  // Instance k: FF type k%3, Gray when (k/3)%2, saturate when k>=6 (reset value 5).
  for (genvar k = 0; k < c_n; k++) begin : g_dut
    localparam int c_ff   = k % 3;
    localparam int c_code = (k / 3) % 2;
    localparam int c_sat  = k / 6;
    localparam int c_rv   = (c_sat != 0) ? 5 : 0;

    param_seq_counter_if #(.WIDTH(c_width)) u_if ();

    assign u_if.x_in     = x_in;
    assign u_if.dir      = dir;
    assign u_if.load     = load;
    assign u_if.load_val = load_val;

    param_seq_counter #(
      .WIDTH(c_width), .FF_TYPE(c_ff), .CODE(c_code),
      .SATURATE(c_sat), .RESET_VAL(c_rv)
    ) u_dut (
      .clock(clock),
      .reset(reset),
      .bus  (u_if.slave)
    );

    assign w_state[k] = u_if.state;
    assign w_tc[k]    = u_if.tc;
    assign w_wrap[k]  = u_if.wrap;
  end

  function automatic int code_of(int k); return (k / 3) % 2; endfunction
  function automatic int sat_of(int k);  return k / 6;       endfunction
  function automatic int rv_of(int k);   return (k >= 6) ? 5 : 0; endfunction

  function automatic int to_gray(int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(int g);
    int b = 0;
    for (int v = g; v != 0; v = v >> 1) b = b ^ v;
    return b;
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit at_end(int k);
    return dir ? (m_cnt[k] == c_max) : (m_cnt[k] == 0);
  endfunction

  task automatic check_all();
    for (int k = 0; k < c_n; k++) begin
      int es;
      bit etc;
      es  = (code_of(k) != 0) ? to_gray(m_cnt[k]) : m_cnt[k];
      etc = !reset && !load && x_in && at_end(k);
      check_eq($sformatf("state[%0d]", k), int'(w_state[k]), es);
      check_eq($sformatf("wrap[%0d]", k), int'(w_wrap[k]), int'(m_wrap[k]));
      check_eq($sformatf("tc[%0d]", k), int'(w_tc[k]), int'(etc));
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < c_n; k++) begin
      bit term;
      term      = at_end(k);
      m_wrap[k] = 1'b0;
      if (reset) begin
        m_cnt[k] = rv_of(k);
      end else if (load) begin
        m_cnt[k] = (code_of(k) != 0) ? from_gray(int'(load_val)) : int'(load_val);
      end else if (x_in) begin
        if (term && sat_of(k) != 0) begin
          m_cnt[k] = m_cnt[k];
        end else begin
          m_cnt[k]  = (m_cnt[k] + (dir ? 1 : -1) + 16) % 16;
          m_wrap[k] = term;
        end
      end
    end
  endtask

  task automatic tick();
    #1 check_all();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic drive(input bit r, input bit l, input bit x, input bit d, input int lv);
    reset    = r;
    load     = l;
    x_in     = x;
    dir      = d;
    load_val = c_width'(lv);
  endtask

  logic [c_width-1:0] gray_seq [6];

  initial begin
    gray_seq[0] = 4'b0000; gray_seq[1] = 4'b0001; gray_seq[2] = 4'b0011;
    gray_seq[3] = 4'b0010; gray_seq[4] = 4'b0110; gray_seq[5] = 4'b0111;

    // Reset dominates load and step; first edge only initialises the registers.
    drive(1, 1, 1, 1, 9);
    @(posedge clock);
    model_step();
    @(negedge clock);
    tick();
    check_eq("reset_state_rv0", int'(w_state[0]), 0);
    check_eq("reset_state_rv5", int'(w_state[6]), 5);
    check_eq("reset_wrap", int'(w_wrap[0]), 0);
    check_eq("reset_tc", int'(w_tc[0]), 0);

    // Count up through the top and back to zero.
    drive(1, 0, 0, 1, 0);
    tick();
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 16; i++) tick();
    check_eq("up_wrap_state", int'(w_state[0]), 0);
    check_eq("up_wrap_pulse", int'(w_wrap[0]), 1);
    tick();
    check_eq("up_wrap_cleared", int'(w_wrap[0]), 0);

    // Gray coded count from zero.
    drive(1, 0, 0, 1, 0);
    tick();
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("gray_seq%0d", i), int'(w_state[3]), int'(gray_seq[i]));
      tick();
    end

    // Down-step at zero: saturating builds hold, wrapping builds roll over.
    drive(0, 1, 0, 1, 0);
    tick();
    drive(0, 0, 1, 0, 0);
    #1 check_eq("down_tc_sat", int'(w_tc[6]), 1);
    tick();
    check_eq("down_sat_state", int'(w_state[6]), 0);
    check_eq("down_sat_wrap", int'(w_wrap[6]), 0);
    check_eq("down_wrap_state", int'(w_state[0]), 15);
    check_eq("down_wrap_pulse", int'(w_wrap[0]), 1);
    drive(0, 0, 0, 0, 0);
    tick();
    check_eq("down_wrap_cleared", int'(w_wrap[0]), 0);

    // Gray load beats step; reset beats load.
    drive(0, 1, 1, 1, 4'b1101);
    tick();
    check_eq("gray_load_state", int'(w_state[3]), 4'b1101);
    check_eq("bin_load_state", int'(w_state[0]), 4'b1101);
    drive(1, 1, 1, 1, 4'b1101);
    tick();
    check_eq("reset_over_load", int'(w_state[3]), 0);
    check_eq("reset_over_load_rv5", int'(w_state[9]), 4'b0111);

    // Random traffic, every build checked every cycle.
    for (int c = 0; c < 2000; c++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            int'($urandom_range(0, 15)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
